calc_arbiter: RTL

- Sequencing controller for the 4-bit calculator ALU datapath. Ops: add, sub, mul, div, mod, invert.
- Shares one datapath between two requesters using a valid/ready request handshake and round-robin arbitration.
- Executes add/sub/mul/invert in one cycle. Executes div/mod as a DW-cycle iterative restoring divider.
- Returns each result to its requester on a valid/ready response channel with an error flag. Invalid ops and divide-by-zero produce an error response, not a simulation message.

---
 rtl/calc_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/calc_arbiter.sv
// Two-requester front end for the 4-bit calculator ALU: round-robin accept, one-cycle
// arithmetic, DW-cycle restoring divide, and a held valid/ready response with an error flag.
module calc_arbiter #(
  parameter int unsigned DW = 4,
  parameter int unsigned OW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [2:0]    req0_oper,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [2:0]    req1_oper,
  output logic          req1_ready,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [OW-1:0] rsp_out,
  output logic          rsp_err,
  output logic          busy
);

  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {StIdle, StDiv, StResp} state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [DW-1:0] b_q, b_d;
  logic [2:0]    oper_q, oper_d;
  logic          id_q, id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [OW-1:0] rsp_out_q, rsp_out_d;
  logic          rsp_err_q, rsp_err_d;

  logic          grant0, grant1, accept;
  logic [DW-1:0] sel_a, sel_b;
  logic [2:0]    sel_oper;
  logic [OW-1:0] a_ext, b_ext, alu_out;
  logic          alu_err, is_div;
  logic [DW:0]   shift, trial;
  logic [DW-1:0] rem_nxt, quo_nxt;

  // Ties go to whichever requester was not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle) begin
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign accept     = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign sel_a      = grant1 ? req1_a : req0_a;
  assign sel_b      = grant1 ? req1_b : req0_b;
  assign sel_oper   = grant1 ? req1_oper : req0_oper;
  assign a_ext      = {{(OW - DW){1'b0}}, sel_a};
  assign b_ext      = {{(OW - DW){1'b0}}, sel_b};
  assign is_div     = (sel_oper == 3'b011) || (sel_oper == 3'b100);

  // Single-cycle results; div/mod only land here when b is zero.
  always_comb begin
    alu_out = '0;
    alu_err = 1'b0;
    case (sel_oper)
      3'b000:  alu_out = a_ext + b_ext;
      3'b001:  alu_out = a_ext - b_ext;
      3'b010:  alu_out = a_ext * b_ext;
      3'b101:  alu_out = ~a_ext;
      default: alu_err = 1'b1;
    endcase
  end

  // One restoring step: bring in the next dividend bit and subtract if it fits.
  always_comb begin
    shift = {rem_q, quo_q[DW-1]};
    trial = shift - {1'b0, b_q};
    if (!trial[DW]) begin
      rem_nxt = trial[DW-1:0];
      quo_nxt = {quo_q[DW-2:0], 1'b1};
    end else begin
      rem_nxt = shift[DW-1:0];
      quo_nxt = {quo_q[DW-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    b_d          = b_q;
    oper_d       = oper_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_out_d    = rsp_out_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          last_grant_d = grant1;
          id_d         = grant1;
          b_d          = sel_b;
          oper_d       = sel_oper;
          if (is_div && (sel_b != '0)) begin
            state_d = StDiv;
            cnt_d   = CW'(DW);
            rem_d   = '0;
            quo_d   = sel_a;
          end else begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant1;
            rsp_out_d   = alu_out;
            rsp_err_d   = alu_err;
          end
        end
      end
      StDiv: begin
        cnt_d = cnt_q - CW'(1);
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        if (cnt_q == CW'(1)) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_err_d   = 1'b0;
          rsp_out_d   = (oper_q == 3'b011) ? {{(OW - DW){1'b0}}, quo_nxt}
                                           : {{(OW - DW){1'b0}}, rem_nxt};
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      b_q          <= '0;
      oper_q       <= '0;
      id_q         <= 1'b0;
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_out_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      b_q          <= b_d;
      oper_q       <= oper_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_out_q    <= rsp_out_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle);

endmodule
